fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 105 ++++++++++
 tb/tb_fifo_reader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// Pops words from an upstream FIFO that has a 1-cycle read latency and presents them
// downstream through a 3-entry in-order skid buffer, with flush and a transfer counter.
`timescale 1ns/1ps

module fifo_reader #(
    parameter int width     = 8,
    parameter int cnt_width = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 fifo_empty_i,
    input  logic [width-1:0]     fifo_dout_i,
    output logic                 fifo_rd_en_o,
    output logic                 m_valid_o,
    output logic [width-1:0]     m_data_o,
    input  logic                 m_ready_i,
    input  logic                 flush_i,
    output logic [cnt_width-1:0] rd_count_o,
    output logic                 busy_o
);

    localparam int depth = 3;

    logic [width-1:0]     mem_q [depth];
    logic [width-1:0]     mem_d [depth];
    logic [1:0]           head_q, head_d;
    logic [1:0]           tail_q, tail_d;
    logic [1:0]           occ_q, occ_d;
    logic                 inf_q, inf_d;
    logic [cnt_width-1:0] count_q, count_d;
    logic [2:0]           pending;
    logic                 capture;
    logic                 pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Read request depends only on registered state, so a word never arrives without a slot.
    always_comb begin
        pending      = {1'b0, occ_q} + {2'b00, inf_q};
        fifo_rd_en_o = reset_i && !fifo_empty_i && !flush_i && (pending < 3'd3);
        m_valid_o    = (occ_q != 2'd0);
        m_data_o     = mem_q[head_q];
        busy_o       = (occ_q != 2'd0) || inf_q;
        rd_count_o   = count_q;
        capture      = inf_q && !flush_i;
        pop          = m_valid_o && m_ready_i && !flush_i;
    end

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        count_d = count_q;
        inf_d   = fifo_rd_en_o;

        if (flush_i) begin
            head_d = 2'd0;
            tail_d = 2'd0;
            occ_d  = 2'd0;
        end else begin
            if (capture) begin
                mem_d[tail_q] = fifo_dout_i;
                tail_d        = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d  = ptr_inc(head_q);
                count_d = count_q + 1'b1;
            end
            case ({capture, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the 3-entry store is reset too, so m_data_o reads 0 while in reset.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < depth; i++) mem_q[i] <= '0;
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            occ_q   <= 2'd0;
            inf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            inf_q   <= inf_d;
            count_q <= count_d;
        end
    end

    // A returning word with the buffer already full would be lost.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_i)
        !(capture && occ_q == 2'd3));

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: an upstream FIFO model feeds the DUT, a scoreboard
// queue holds the words expected downstream, and a monitor pops it on every transfer.
`timescale 1ns/1ps

module tb_fifo_reader;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        fifo_empty_i = 1'b1;
    logic [7:0]  fifo_dout_i = 8'h00;
    logic        m_ready_i = 1'b0;
    logic        flush_i = 1'b0;

    logic        fifo_rd_en_o, m_valid_o, busy_o;
    logic [7:0]  m_data_o;
    logic [15:0] rd_count_o;

    logic        rd_en4, valid4, busy4;
    logic [7:0]  data4;
    logic [3:0]  count4;

    fifo_reader #(.width(8), .cnt_width(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .fifo_empty_i(fifo_empty_i),
        .fifo_dout_i(fifo_dout_i), .fifo_rd_en_o(fifo_rd_en_o), .m_valid_o(m_valid_o),
        .m_data_o(m_data_o), .m_ready_i(m_ready_i), .flush_i(flush_i),
        .rd_count_o(rd_count_o), .busy_o(busy_o)
    );

    fifo_reader #(.width(8), .cnt_width(4)) dut4 (
        .clk_i(clk_i), .reset_i(reset_i), .fifo_empty_i(fifo_empty_i),
        .fifo_dout_i(fifo_dout_i), .fifo_rd_en_o(rd_en4), .m_valid_o(valid4),
        .m_data_o(data4), .m_ready_i(m_ready_i), .flush_i(flush_i),
        .rd_count_o(count4), .busy_o(busy4)
    );

    always #10 clk_i = ~clk_i;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         rd_pulses = 0;
    logic [7:0] upq[$];
    logic [7:0] expq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample the pop request mid-cycle, then the upstream FIFO answers after the edge.
    task automatic tick();
        logic rd;
        @(negedge clk_i);
        rd = fifo_rd_en_o;
        @(posedge clk_i);
        #1;
        if (rd) begin
            rd_pulses++;
            if (upq.size() > 0) fifo_dout_i = upq.pop_front();
        end
        fifo_empty_i = (upq.size() == 0);
    endtask

    task automatic load(input logic [7:0] w, input bit expected);
        upq.push_back(w);
        if (expected) expq.push_back(w);
        fifo_empty_i = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int i = 0;
        while ((expq.size() != 0 || m_valid_o) && i < max_cycles) begin
            tick();
            i++;
        end
        check("drain_left", 32'(expq.size()), 32'd0);
    endtask

    // Scoreboard monitor: a transfer is valid && ready outside flush and reset.
    initial begin
        logic [7:0] w;
        forever begin
            @(negedge clk_i);
            if (reset_i && !flush_i && m_valid_o && m_ready_i) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_extra: got 0x%0h, want no word", m_data_o);
                end else begin
                    w = expq.pop_front();
                    check("sb_data", 32'(m_data_o), 32'(w));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, with a non-empty FIFO to show the pop request stays low.
        fifo_empty_i = 1'b0;
        #5;
        check("rst_rd_en", 32'(fifo_rd_en_o), 32'd0);
        check("rst_valid", 32'(m_valid_o), 32'd0);
        check("rst_data",  32'(m_data_o), 32'd0);
        check("rst_count", 32'(rd_count_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);
        fifo_empty_i = 1'b1;
        #20;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Stream 0x01..0x08 with ready held: 2-cycle fill then one word per cycle.
        m_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) load(8'(i), 1'b1);
        tick();
        check("lat_valid_c1", 32'(m_valid_o), 32'd0);
        tick();
        check("lat_valid_c2", 32'(m_valid_o), 32'd1);
        check("lat_data_c2",  32'(m_data_o), 32'h01);
        for (int i = 0; i < 8; i++) begin
            check("stream_valid", 32'(m_valid_o), 32'd1);
            tick();
        end
        check("stream_end_valid", 32'(m_valid_o), 32'd0);
        check("stream_count",     32'(rd_count_o), 32'd8);
        check("stream_count4",    32'(count4), 32'd8);
        check("stream_busy",      32'(busy_o), 32'd0);

        // Backpressure: only three pops fit, head word held.
        m_ready_i = 1'b0;
        rd_pulses = 0;
        for (int i = 0; i < 5; i++) load(8'h11 + 8'(i), 1'b1);
        repeat (10) tick();
        check("bp_rd_pulses", 32'(rd_pulses), 32'd3);
        check("bp_occ",       32'(dut.occ_q), 32'd3);
        check("bp_head",      32'(m_data_o), 32'h11);
        m_ready_i = 1'b1;
        drain(50);
        check("bp_count", 32'(rd_count_o), 32'd13);

        // Alternating ready over 16 words.
        for (int i = 0; i < 16; i++) load(8'h40 + 8'(i), 1'b1);
        for (int i = 0; i < 80 && (expq.size() != 0 || m_valid_o); i++) begin
            m_ready_i = (i % 2 == 0);
            tick();
        end
        check("alt_left", 32'(expq.size()), 32'd0);
        m_ready_i = 1'b1;
        check("alt_count", 32'(rd_count_o), 32'd29);

        // Flush with two words buffered and one in flight; all three are dropped.
        m_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) load(8'h71 + 8'(i), 1'b0);
        repeat (3) tick();
        check("fl_pre_occ", 32'(dut.occ_q), 32'd2);
        check("fl_pre_inf", 32'(dut.inf_q), 32'd1);
        flush_i   = 1'b1;
        m_ready_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("fl_valid", 32'(m_valid_o), 32'd0);
        check("fl_busy",  32'(busy_o), 32'd0);
        check("fl_count", 32'(rd_count_o), 32'd29);
        load(8'hA5, 1'b1);
        drain(20);
        check("fl_after_count",  32'(rd_count_o), 32'd30);
        check("fl_after_count4", 32'(count4), 32'd14);

        // Asynchronous reset pulse mid-stream, between clock edges.
        for (int i = 1; i <= 6; i++) load(8'(i), 1'b1);
        repeat (3) tick();
        #2;
        reset_i = 1'b0;
        upq.delete();
        expq.delete();
        fifo_empty_i = 1'b0;
        #2;
        check("arst_rd_en", 32'(fifo_rd_en_o), 32'd0);
        check("arst_valid", 32'(m_valid_o), 32'd0);
        check("arst_data",  32'(m_data_o), 32'd0);
        check("arst_count", 32'(rd_count_o), 32'd0);
        check("arst_busy",  32'(busy_o), 32'd0);
        fifo_empty_i = 1'b1;
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_rel_valid", 32'(m_valid_o), 32'd0);
        tick();
        check("arst_stale_valid", 32'(m_valid_o), 32'd0);

        // Resume with 17 words: the 4-bit counter wraps to 1.
        for (int i = 0; i < 17; i++) load(8'h80 + 8'(i), 1'b1);
        drain(100);
        check("wrap_count16", 32'(rd_count_o), 32'd17);
        check("wrap_count4",  32'(count4), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
